// File: rtl/cond_logic_if.sv
// Purpose: bundles the instruction-control and flag signals of the ARM-style condition unit.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is sampled or driven on every cycle.
//
// Ports (master = instruction decoder side, slave = cond_logic):
//   Cond[3:0]      condition field, EQ (0000) .. AL (1110); 1111 reserved
//   ALUFlags[3:0]  {N,Z,C,V} produced by the ALU for the current instruction
//   FlagW[1:0]     [1] requests an N,Z update, [0] requests a C,V update
//   PCS/RegW/MemW  ungated write requests (PC, register file, memory)
//   NoWrite        compare-class instruction, suppresses the register write
//   PCSrc/RegWrite/MemWrite  writes gated by the condition result
//   Flags[3:0]     architectural flags {N,Z,C,V}
//   CondEx         condition of the current instruction passed
interface cond_logic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, Flags, CondEx
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, Flags, CondEx
  );
endinterface

// File: rtl/cond_logic.sv
// Purpose: evaluates the ARM condition field against the stored flags, gates writes, updates flags.
// Latency: gated writes and CondEx are combinational; flag updates are visible one cycle later.
// Backpressure: none; one instruction is accepted every cycle.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high reset, clears the flags to 0000
//   bus    cond_logic_if.slave carrying the instruction controls and gated outputs
module cond_logic (
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);

  logic [1:0] r_nz;        // {N,Z}
  logic [1:0] r_cv;        // {C,V}
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_cond_ex;

  assign {w_n, w_z} = r_nz;
  assign {w_c, w_v} = r_cv;

  // Only the registered flags feed the condition; the ALU flags of this
  // cycle belong to the instruction being evaluated and must not affect it.
  always_comb begin
    w_cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: w_cond_ex = w_z;                       // EQ
      4'b0001: w_cond_ex = ~w_z;                      // NE
      4'b0010: w_cond_ex = w_c;                       // CS
      4'b0011: w_cond_ex = ~w_c;                      // CC
      4'b0100: w_cond_ex = w_n;                       // MI
      4'b0101: w_cond_ex = ~w_n;                      // PL
      4'b0110: w_cond_ex = w_v;                       // VS
      4'b0111: w_cond_ex = ~w_v;                      // VC
      4'b1000: w_cond_ex = w_c & ~w_z;                // HI
      4'b1001: w_cond_ex = ~w_c | w_z;                // LS
      4'b1010: w_cond_ex = ~(w_n ^ w_v);              // GE
      4'b1011: w_cond_ex = w_n ^ w_v;                 // LT
      4'b1100: w_cond_ex = ~w_z & ~(w_n ^ w_v);       // GT
      4'b1101: w_cond_ex = w_z | (w_n ^ w_v);         // LE
      4'b1110: w_cond_ex = 1'b1;                      // AL
      default: w_cond_ex = 1'b0;                      // 1111 reserved: never executes
    endcase
  end

  // Each flag half updates independently, and only when the instruction
  // actually executes. Reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nz <= 2'b00;
      r_cv <= 2'b00;
    end else begin
      if (bus.FlagW[1] && w_cond_ex) begin
        r_nz <= bus.ALUFlags[3:2];
      end
      if (bus.FlagW[0] && w_cond_ex) begin
        r_cv <= bus.ALUFlags[1:0];
      end
    end
  end

  assign bus.CondEx   = w_cond_ex;
  assign bus.Flags    = {r_nz, r_cv};
  assign bus.PCSrc    = bus.PCS & w_cond_ex;
  assign bus.RegWrite = bus.RegW & w_cond_ex & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & w_cond_ex;

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cond_logic_if bus ();

  cond_logic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cond, input logic [1:0] flagw, input logic [3:0] alu,
                       input logic pcs, input logic regw, input logic memw, input logic nowrite);
    bus.Cond     = cond;
    bus.FlagW    = flagw;
    bus.ALUFlags = alu;
    bus.PCS      = pcs;
    bus.RegW     = regw;
    bus.MemW     = memw;
    bus.NoWrite  = nowrite;
    #1;
  endtask

  // Hand-written condition table, flags given as {N,Z,C,V}.
  function automatic logic exp_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset state and combinational behaviour during reset
    chk("reset_flags", bus.Flags, 4'b0000);
    chk("reset_eq_condex", {3'b0, bus.CondEx}, 4'b0000);
    drive(4'b1110, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset_al_regwrite", {3'b0, bus.RegWrite}, 4'b0001);
    tick();
    chk("reset_beats_flagw", bus.Flags, 4'b0000);
    reset = 1'b0;

    // AL writes Z, then EQ passes
    drive(4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("al_flags_0100", bus.Flags, 4'b0100);
    drive(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("eq_after_update", {3'b0, bus.CondEx}, 4'b0001);

    // NE fails with Z=1: every write suppressed, flags included
    drive(4'b0001, 2'b11, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ne_condex", {3'b0, bus.CondEx}, 4'b0000);
    chk("ne_writes", {1'b0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'b0000);
    tick();
    chk("ne_flags_hold", bus.Flags, 4'b0100);

    // EQ passes: every write enabled
    drive(4'b0000, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("eq_writes", {1'b0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'b0111);
    tick();
    chk("eq_flags_hold", bus.Flags, 4'b0100);

    // Clear flags, then same-cycle ALU flags must not affect CondEx
    drive(4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("clear_flags", bus.Flags, 4'b0000);
    drive(4'b0000, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu_no_bypass", {3'b0, bus.CondEx}, 4'b0000);
    tick();
    chk("failed_no_flagw", bus.Flags, 4'b0000);

    // Independent halves
    drive(4'b1110, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("nz_only", bus.Flags, 4'b1100);
    drive(4'b1110, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("cv_only", bus.Flags, 4'b1111);

    // CMP: flags update, register write suppressed
    drive(4'b1110, 2'b11, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("cmp_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
    tick();
    chk("cmp_flags", bus.Flags, 4'b1001);

    // Sweep every condition against every flag value
    for (int f = 0; f < 16; f++) begin
      drive(4'b1110, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("sweep_load", bus.Flags, 4'(f));
      for (int c = 0; c < 16; c++) begin
        drive(4'(c), 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, bus.CondEx}, {3'b0, exp_cond(4'(c), 4'(f))});
      end
    end

    // Mid-sequence reset discards the pending update
    drive(4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_reset_flags", bus.Flags, 4'b1111);
    reset = 1'b1;
    drive(4'b1110, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mid_reset_flags", bus.Flags, 4'b0000);
    reset = 1'b0;
    drive(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_reset_hold", bus.Flags, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
